// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one cipher round per clock, valid/ready on both sides.
// Round keys come straight off the expanded-key bus, which must stay stable while a block runs.
module aes_cipher_core #(
   parameter int unsigned DATA_WIDTH           = 128,
   parameter int unsigned EXPANSIONED_KEY_SIZE = 1408,
   parameter int unsigned NUM_OF_ROUNDS        = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [EXPANSIONED_KEY_SIZE-1:0] expansioned_key,
   input  logic [DATA_WIDTH-1:0]           in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy
);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   localparam logic [3:0] LastRound = 4'(NUM_OF_ROUNDS);
   localparam int unsigned NumKeys = NUM_OF_ROUNDS + 1;

   // FIPS-197 S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] idx;
      idx = {~x, 3'b000};
      return SBOX[idx +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes + ShiftRows, then MixColumns unless this is the final round.
   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
      logic [7:0]   sb [16];
      logic [7:0]   sr [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         if (last) begin
            r[127-32*c -: 32] = {a0, a1, a2, a3};
         end else begin
            r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
         end
      end
      return r;
   endfunction

   state_e                fsm_q, fsm_d;
   logic [DATA_WIDTH-1:0] st_q, st_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  rdy_en_q;
   logic [DATA_WIDTH-1:0] rk [16];
   logic [DATA_WIDTH-1:0] round_out;

   always_comb begin
      for (int i = 0; i < 16; i++) rk[i] = '0;
      for (int i = 0; i < NumKeys; i++) begin
         rk[i] = expansioned_key[EXPANSIONED_KEY_SIZE-1-DATA_WIDTH*i -: DATA_WIDTH];
      end
   end

   assign round_out = round_fn(st_q, cnt_q == LastRound) ^ rk[cnt_q];

   always_comb begin
      fsm_d     = fsm_q;
      st_d      = st_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (fsm_q)
         StIdle: begin
            in_ready = rdy_en_q;
            if (in_valid && rdy_en_q) begin
               st_d  = in_data ^ rk[0];
               cnt_d = 4'd1;
               fsm_d = StRound;
            end
         end
         StRound: begin
            busy  = 1'b1;
            st_d  = round_out;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LastRound) begin
               out_d = round_out;
               cnt_d = 4'd0;
               fsm_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               fsm_d = StIdle;
               // Output handshake and new acceptance share the edge: no idle bubble.
               if (in_valid) begin
                  st_d  = in_data ^ rk[0];
                  cnt_d = 4'd1;
                  fsm_d = StRound;
               end
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q    <= StIdle;
         st_q     <= '0;
         out_q    <= '0;
         cnt_q    <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         st_q     <= st_d;
         out_q    <= out_d;
         cnt_q    <= cnt_d;
         rdy_en_q <= 1'b1;
      end
   end

   assign out_data = out_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboard bench for aes_cipher_core using the FIPS-197 App. B and App. C.1 vectors.
// Round keys are expanded here, standing in for the upstream key expansion stage.
module tb_aes_cipher_core;

   localparam int unsigned DW = 128;
   localparam int unsigned EK = 1408;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [EK-1:0] ekey = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [DW-1:0] exp_q [$];
   int            acc_q [$];
   logic          ov_prev = 1'b0;

   aes_cipher_core dut (
      .clk             (clk),
      .rst             (rst),
      .expansioned_key (ekey),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [10:0] idx;
      idx = {~x, 3'b000};
      return SBOX[idx +: 8];
   endfunction

   function automatic logic [EK-1:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [EK-1:0] e;
      rc = 8'h01;
      e  = '0;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
            t[31:24] = t[31:24] ^ rc;
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) e[EK-1-32*i -: 32] = w[i];
      return e;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no event, required one", name);
   endtask

   // Monitor: accept times, out_valid latency, and ciphertext at each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         if (in_valid && in_ready) acc_q.push_back(cyc + 1);
         if (out_valid && !ov_prev) begin
            if (acc_q.size() == 0) fail("latency_accept");
            else check("latency", 128'(cyc - acc_q.pop_front()), 128'd10);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail("unexpected_output");
            else check("ciphertext", out_data, exp_q.pop_front());
         end
      end
      ov_prev = out_valid;
   end

   task automatic wait_out();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("timeout_out_valid");
   endtask

   task automatic send(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
      bit ok;
      ekey     = expand(key);
      in_data  = pt;
      in_valid = 1'b1;
      exp_q.push_back(ct);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("timeout_in_ready");
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2;
      #12;
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check("ready_after_rst", 128'(in_ready), 128'd1);

      // App. B and App. C.1 single blocks.
      send(KEY_B, PT_B, CT_B);
      check("busy_round", 128'(busy), 128'd1);
      wait_out();
      @(posedge clk);
      #1 check("valid_drop_b", 128'(out_valid), 128'd0);
      send(KEY_C, PT_C, CT_C);
      wait_out();
      @(posedge clk);
      #1;

      // Backpressure.
      out_ready = 1'b0;
      send(KEY_B, PT_B, CT_B);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 128'(out_valid), 128'd1);
         check("bp_data", out_data, CT_B);
         check("bp_in_ready", 128'(in_ready), 128'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 check("bp_valid_drop", 128'(out_valid), 128'd0);

      // Back-to-back with in_valid held high; key swapped after block 1's last round.
      ekey     = expand(KEY_B);
      in_data  = PT_B;
      in_valid = 1'b1;
      exp_q.push_back(CT_B);
      exp_q.push_back(CT_C);
      @(negedge clk);
      a1 = cyc + 1;
      check("b2b_first_ready", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1 in_data = PT_C;
      wait_out();
      a2 = cyc + 1;
      ekey = expand(KEY_C);
      check("b2b_ready_in_done", 128'(in_ready), 128'd1);
      check("b2b_period", 128'(a2 - a1), 128'd11);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("b2b_busy", 128'(busy), 128'd1);
      wait_out();
      @(posedge clk);
      #1;

      // Reset during round 5.
      send(KEY_B, PT_B, CT_B);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'd0);
      check("midrst_busy", 128'(busy), 128'd0);
      check("midrst_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", 128'(in_ready), 128'd1);
      check("post_rst_busy", 128'(busy), 128'd0);
      check("post_rst_valid", 128'(out_valid), 128'd0);
      send(KEY_B, PT_B, CT_B);
      wait_out();
      @(posedge clk);
      #1;

      // in_valid pulsed mid-block must be ignored.
      send(KEY_C, PT_C, CT_C);
      repeat (2) @(posedge clk);
      #1 in_data = PT_B;
      in_valid = 1'b1;
      check("pulse_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_data = '0;
      wait_out();
      repeat (15) @(posedge clk);
      #1 check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
